// File: rtl/serial_subtractor_ovf_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t : FSM state encoding (IDLE/SHIFT/DONE, original 2-bit codes kept)
//   ovf_of  : signed overflow from the carries into and out of the MSB
package serial_subtractor_ovf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic ovf_of(input logic cin_msb, input logic cout_msb);
    return cin_msb ^ cout_msb;
  endfunction

endpackage

// File: rtl/serial_subtractor_ovf_if.sv
// Handshake/operand bundle for serial_subtractor_ovf.
//   start, A, B                      : requester -> subtractor
//   busy, done, Diff, Overflow, Borrow : subtractor -> requester
// master modport = requester side, slave modport = subtractor side.
interface serial_subtractor_ovf_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Overflow;
  logic             Borrow;

  modport master (
    output start, A, B,
    input  busy, done, Diff, Overflow, Borrow
  );

  modport slave (
    input  start, A, B,
    output busy, done, Diff, Overflow, Borrow
  );
endinterface

// File: rtl/serial_subtractor_ovf_full_adder.sv
// Single-bit full adder cell shared with the parallel adder.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_subtractor_ovf.sv
// Bit-serial two's-complement subtractor: Diff = A - B, LSB first, one bit
// per clock, computed as A + ~B + 1 through a single full_adder cell.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_ovf_if.slave (start/A/B in; busy/done/Diff/
//           Overflow/Borrow out). done pulses one cycle, WIDTH cycles after
//           the accepting edge; Diff/Overflow/Borrow hold until the next result.
// Optional build macro SUB_SATURATE_EN: on signed overflow Diff clamps to
// the signed max (A positive) or min (A negative) instead of wrapping.
module serial_subtractor_ovf
  import serial_subtractor_ovf_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_subtractor_ovf_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, nb_sr, res_sr;
  logic [WIDTH-1:0] diff_q, diff_next, wrapped;
  logic [CW-1:0]    cnt;
  logic             carry, ovf_q, bor_q;
  logic             fa_sum, fa_cout;
  logic             accept, last_bit;

  full_adder u_fa (
    .a   (a_sr[0]),
    .b   (nb_sr[0]),
    .cin (carry),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  assign accept   = (state == S_IDLE) && bus.start;
  assign last_bit = (state == S_SHIFT) && (cnt == LAST);
  assign wrapped  = {fa_sum, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (bus.start) next_state = S_SHIFT;
      S_SHIFT: if (cnt == LAST) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // On the final bit the operand register has shifted A's MSB down to
  // a_sr[0], so the clamp direction is taken from there.
  always_comb begin
    diff_next = wrapped;
`ifdef SUB_SATURATE_EN
    if (ovf_of(carry, fa_cout))
      diff_next = a_sr[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      nb_sr  <= '0;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      diff_q <= '0;
      ovf_q  <= 1'b0;
      bor_q  <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.A;
      nb_sr  <= ~bus.B;
      res_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b1;
    end else if (state == S_SHIFT) begin
      res_sr <= wrapped;
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      nb_sr  <= {1'b0, nb_sr[WIDTH-1:1]};
      carry  <= fa_cout;
      cnt    <= cnt + CW'(1);
      // Published result regs update only here, so Diff stays stable while
      // later bits are still being shifted.
      if (last_bit) begin
        diff_q <= diff_next;
        ovf_q  <= ovf_of(carry, fa_cout);
        bor_q  <= ~fa_cout;
      end
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.Diff     = diff_q;
  assign bus.Overflow = ovf_q;
  assign bus.Borrow   = bor_q;

endmodule

// File: tb/tb_serial_subtractor_ovf.sv
// Scoreboard bench for serial_subtractor_ovf (WIDTH=4): directed vectors push
// hand-computed results; a negedge monitor pops and compares on each done.
module tb_serial_subtractor_ovf;

  typedef struct packed {
    logic [3:0] d;
    logic       o;
    logic       b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nchk  = 0;
  int   nfail = 0;
  int   ndone = 0;
  exp_t sb[$];
  exp_t hold;

  serial_subtractor_ovf_if #(.WIDTH(4)) bus ();

  serial_subtractor_ovf #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: compare on done, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    exp_t got, e;
    got = {bus.Diff, bus.Overflow, bus.Borrow};
    if (!rst_n) begin
      sb.delete();
      hold = '0;
    end else if (bus.done) begin
      ndone++;
      if (sb.size() == 0) begin
        check("unexpected_done", 8'd1, 8'd0);
      end else begin
        e = sb.pop_front();
        check("result", 8'(got), 8'(e));
        hold = e;
      end
    end else begin
      check("hold", 8'(got), 8'(hold));
    end
  end

  task automatic wait_idle();
    @(negedge clk);
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
  endtask

  // Drive an op at a negedge, accepted at the following posedge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input exp_t e);
    wait_idle();
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    sb.push_back(e);
    @(posedge clk); #1;
    check("accept_busy", 8'(bus.busy), 8'd1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int req_lat, input string name);
    int n;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        n = i;
        break;
      end
    end
    check(name, 8'(n), 8'(req_lat));
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input exp_t e, input string name);
    issue(a, b, e);
    wait_done(4, name);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    hold      = '0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 8'(bus.busy), 8'd0);
    check("rst_done", 8'(bus.done), 8'd0);
    check("rst_out", 8'({bus.Diff, bus.Overflow, bus.Borrow}), 8'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    op(4'b0101, 4'b0011, '{4'b0010, 1'b0, 1'b0}, "t1_latency");
    op(4'b0011, 4'b0101, '{4'b1110, 1'b0, 1'b1}, "t2_latency");
`ifdef SUB_SATURATE_EN
    op(4'b0111, 4'b1111, '{4'b0111, 1'b1, 1'b1}, "t3_latency");
    op(4'b1000, 4'b0001, '{4'b1000, 1'b1, 1'b0}, "t4_latency");
`else
    op(4'b0111, 4'b1111, '{4'b1000, 1'b1, 1'b1}, "t3_latency");
    op(4'b1000, 4'b0001, '{4'b0111, 1'b1, 1'b0}, "t4_latency");
`endif
    op(4'b0000, 4'b0001, '{4'b1111, 1'b0, 1'b1}, "e1_latency");
    op(4'b1111, 4'b1111, '{4'b0000, 1'b0, 1'b0}, "e2_latency");

    // Test 5: start/A change mid-operation must be ignored.
    issue(4'b0110, 4'b0001, '{4'b0101, 1'b0, 1'b0});
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.A = 4'b1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(2, "t5_latency");

    // Back-to-back with start held high: second accept in first IDLE cycle.
    wait_idle();
    bus.start = 1'b1;
    bus.A = 4'b1001;
    bus.B = 4'b0110;
`ifdef SUB_SATURATE_EN
    sb.push_back('{4'b1000, 1'b1, 1'b0});
    sb.push_back('{4'b1000, 1'b1, 1'b0});
`else
    sb.push_back('{4'b0011, 1'b1, 1'b0});
    sb.push_back('{4'b0011, 1'b1, 1'b0});
`endif
    wait_done(5, "b2b_first");
    @(posedge clk); #1;
    check("b2b_idle", 8'(bus.busy), 8'd0);
    @(posedge clk); #1;
    check("b2b_reaccept", 8'(bus.busy), 8'd1);
    bus.start = 1'b0;
    wait_done(4, "b2b_second");

    // Test 6: async reset mid-operation discards it.
    issue(4'b0101, 4'b0011, '{4'b0010, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t6_busy", 8'(bus.busy), 8'd0);
    check("t6_done", 8'(bus.done), 8'd0);
    check("t6_out", 8'({bus.Diff, bus.Overflow, bus.Borrow}), 8'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    op(4'b0100, 4'b0100, '{4'b0000, 1'b0, 1'b0}, "t6_latency");

    repeat (4) @(negedge clk);
    #1;
    check("sb_empty", 8'(sb.size()), 8'd0);
    check("done_count", 8'(ndone), 8'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
